jam_cost_eval: RTL and testbench

Consumer of the job-assignment permutation stream: on each `start` it latches an 8-entry worker→job permutation, drives the 8 cost-ROM reads (W, J), accumulates the returned costs, and folds the total into a running minimum with a tie count. It sits between the permutation generator and the top-level result outputs, and raises `Valid` once the final permutation has been evaluated.

---
 rtl/jam_pkg.sv | 22 ++
 rtl/jam_min_tracker.sv | 38 +++
 rtl/jam_cost_eval.sv | 131 +++++++++++++
 tb/tb_jam_cost_eval.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// Shared types and sizes for the job-assignment cost evaluator.
// Imported by jam_cost_eval and jam_min_tracker.
package jam_pkg;

  localparam int N      = 8;
  localparam int IDX_W  = 3;
  localparam int COST_W = 7;
  localparam int SUM_W  = 10;
  localparam int CNT_W  = 4;

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DRAIN  = 3'd2;
  localparam state_t S_UPDATE = 3'd3;
  localparam state_t S_DONE   = 3'd4;

endpackage

// File: rtl/jam_min_tracker.sv
// Running minimum of permutation totals with a saturating tie count.
// A restart strobe reopens the run with MinCost all ones.
module jam_min_tracker
  import jam_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             restart_i,
  input  logic             update_i,
  input  logic [SUM_W-1:0] acc_i,
  output logic [SUM_W-1:0] min_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [SUM_W-1:0] min_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      min_q <= '1;
      cnt_q <= '0;
    end else if (restart_i) begin
      min_q <= '1;
      cnt_q <= '0;
    end else if (update_i) begin
      if (acc_i < min_q) begin
        min_q <= acc_i;
        cnt_q <= CNT_W'(1);
      end else if (acc_i == min_q && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign min_o = min_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/jam_cost_eval.sv
// Evaluates one worker->job permutation per start against the cost ROM
// and folds each total into the run's minimum / tie count.
module jam_cost_eval
  import jam_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              last,
  input  logic [IDX_W-1:0]  p_0,
  input  logic [IDX_W-1:0]  p_1,
  input  logic [IDX_W-1:0]  p_2,
  input  logic [IDX_W-1:0]  p_3,
  input  logic [IDX_W-1:0]  p_4,
  input  logic [IDX_W-1:0]  p_5,
  input  logic [IDX_W-1:0]  p_6,
  input  logic [IDX_W-1:0]  p_7,
  output logic [IDX_W-1:0]  W,
  output logic [IDX_W-1:0]  J,
  input  logic [COST_W-1:0] Cost,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  MinCost,
  output logic [CNT_W-1:0]  MatchCount,
  output logic              Valid
);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic             valid_q, valid_d;
  logic             last_q;
  logic [IDX_W-1:0] perm_q [N];
  logic [IDX_W-1:0] p_in [N];
  logic             load;
  logic             restart;
  logic             update;
  logic [SUM_W-1:0] cost_ext;

  assign p_in[0] = p_0;
  assign p_in[1] = p_1;
  assign p_in[2] = p_2;
  assign p_in[3] = p_3;
  assign p_in[4] = p_4;
  assign p_in[5] = p_5;
  assign p_in[6] = p_6;
  assign p_in[7] = p_7;

  assign cost_ext = SUM_W'(Cost);
  assign load     = (state_q == S_IDLE) && start;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    restart = 1'b0;
    update  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = '0;
          acc_d   = '0;
          state_d = S_FETCH;
          if (valid_q) begin
            restart = 1'b1;
            valid_d = 1'b0;
          end
        end
      end
      S_FETCH: begin
        // ROM data lags the address by one cycle
        if (k_q != '0) acc_d = acc_q + cost_ext;
        if (k_q == K_LAST) state_d = S_DRAIN;
        else k_d = k_q + IDX_W'(1);
      end
      S_DRAIN: begin
        acc_d   = acc_q + cost_ext;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        update  = 1'b1;
        if (last_q) valid_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      if (load) last_q <= last;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N; i++) perm_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < N; i++) perm_q[i] <= p_in[i];
    end
  end

  jam_min_tracker u_min (
    .CLK       (CLK),
    .RST       (RST),
    .restart_i (restart),
    .update_i  (update),
    .acc_i     (acc_q),
    .min_o     (MinCost),
    .cnt_o     (MatchCount)
  );

  assign W     = k_q;
  assign J     = perm_q[k_q];
  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign Valid = valid_q;

endmodule

// File: tb/tb_jam_cost_eval.sv
// Directed bench for jam_cost_eval with a registered cost ROM model.
// ROM mode 0: 8W+J, mode 1: 127, mode 2: 50 on W==J else 25.
module tb_jam_cost_eval;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic       last;
  logic [2:0] p [8];
  logic [2:0] W, J;
  logic [6:0] Cost;
  logic       busy, done, Valid;
  logic [9:0] MinCost;
  logic [3:0] MatchCount;
  int         mode;
  int         total = 0;
  int         bad = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    case (mode)
      0: Cost <= 7'(8 * int'(W) + int'(J));
      1: Cost <= 7'd127;
      default: Cost <= (W == J) ? 7'd50 : 7'd25;
    endcase
  end

  jam_cost_eval dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .last       (last),
    .p_0        (p[0]),
    .p_1        (p[1]),
    .p_2        (p[2]),
    .p_3        (p[3]),
    .p_4        (p[4]),
    .p_5        (p[5]),
    .p_6        (p[6]),
    .p_7        (p[7]),
    .W          (W),
    .J          (J),
    .Cost       (Cost),
    .busy       (busy),
    .done       (done),
    .MinCost    (MinCost),
    .MatchCount (MatchCount),
    .Valid      (Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_p(input logic [23:0] pv);
    for (int i = 0; i < 8; i++) p[i] = pv[3*i +: 3];
  endtask

  // Drives one permutation and checks W/J/busy/done cycle by cycle;
  // returns positioned in cycle 11. With iso set, p_* are changed at
  // cycle 2 and start is re-pulsed at cycle 5.
  task automatic run_perm(input logic [23:0] pv, input logic lst,
                          input bit iso, input logic [23:0] alt);
    @(negedge CLK);
    set_p(pv);
    last  = lst;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      if (iso && c == 2) set_p(alt);
      if (iso && c == 5) begin
        start = 1'b1;
        last  = 1'b0;
      end
      if (iso && c == 6) start = 1'b0;
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), (c == 11) ? 32'd1 : 32'd0);
      if (c <= 8) begin
        chk("W", 32'(W), 32'(c - 1));
        chk("J", 32'(J), 32'(pv[3*(c-1) +: 3]));
      end
      if (c < 11) @(negedge CLK);
    end
  endtask

  task automatic chk_res(input string tag, input int mc, input int cnt,
                         input int vld);
    chk({tag, ".MinCost"}, 32'(MinCost), 32'(mc));
    chk({tag, ".MatchCount"}, 32'(MatchCount), 32'(cnt));
    chk({tag, ".Valid"}, 32'(Valid), 32'(vld));
  endtask

  task automatic chk_idle(input string tag);
    @(negedge CLK);
    chk({tag, ".busy12"}, 32'(busy), 32'd0);
    chk({tag, ".done12"}, 32'(done), 32'd0);
  endtask

  localparam logic [23:0] P_ID  = {3'd7, 3'd6, 3'd5, 3'd4,
                                   3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [23:0] P_REV = {3'd0, 3'd1, 3'd2, 3'd3,
                                   3'd4, 3'd5, 3'd6, 3'd7};
  // four fixed points -> 4*50+4*25 = 300
  localparam logic [23:0] P_A = {3'd6, 3'd7, 3'd4, 3'd5,
                                 3'd3, 3'd2, 3'd1, 3'd0};
  // two fixed points -> 2*50+6*25 = 250
  localparam logic [23:0] P_B = {3'd6, 3'd7, 3'd4, 3'd5,
                                 3'd2, 3'd3, 3'd1, 3'd0};
  localparam logic [23:0] P_C = {3'd6, 3'd7, 3'd4, 3'd5,
                                 3'd3, 3'd2, 3'd0, 3'd1};

  initial begin
    RST   = 1'b1;
    start = 1'b0;
    last  = 1'b0;
    mode  = 0;
    set_p(24'd0);
    repeat (3) @(negedge CLK);
    chk("rst.MinCost", 32'(MinCost), 32'd1023);
    chk("rst.MatchCount", 32'(MatchCount), 32'd0);
    chk("rst.Valid", 32'(Valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.W", 32'(W), 32'd0);
    chk("rst.J", 32'(J), 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // identity, sum of 9k = 252
    mode = 0;
    run_perm(P_ID, 1'b1, 1'b0, 24'd0);
    chk_res("ident", 252, 1, 1);
    chk_idle("ident");

    mode = 2;
    run_perm(P_A, 1'b0, 1'b0, 24'd0);
    chk_res("three.a", 300, 1, 0);
    chk_idle("three.a");
    run_perm(P_B, 1'b0, 1'b0, 24'd0);
    chk_res("three.b", 250, 1, 0);
    chk_idle("three.b");
    run_perm(P_C, 1'b1, 1'b0, 24'd0);
    chk_res("three.c", 250, 2, 1);
    chk_idle("three.c");

    mode = 1;
    for (int i = 1; i <= 17; i++) begin
      run_perm((i % 2 == 0) ? P_REV : P_ID, (i == 17), 1'b0, 24'd0);
      if (i == 1)  chk_res("sat.1", 1016, 1, 0);
      if (i == 14) chk_res("sat.14", 1016, 14, 0);
      if (i == 15) chk_res("sat.15", 1016, 15, 0);
      if (i == 16) chk_res("sat.16", 1016, 15, 0);
    end
    chk_res("sat.17", 1016, 15, 1);

    mode = 0;
    run_perm(P_REV, 1'b1, 1'b1, P_A);
    chk_res("iso", 252, 1, 1);
    for (int c = 12; c <= 16; c++) begin
      @(negedge CLK);
      chk("iso.nodone", 32'(done), 32'd0);
      chk("iso.nobusy", 32'(busy), 32'd0);
    end

    // reset in cycle 6 of an evaluation
    mode = 2;
    @(negedge CLK);
    set_p(P_B);
    last  = 1'b1;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.W", 32'(W), 32'd0);
    chk("mid.J", 32'(J), 32'd0);
    chk_res("mid", 1023, 0, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("mid.nodone", 32'(done), 32'd0);
    end
    mode = 0;
    run_perm(P_ID, 1'b1, 1'b0, 24'd0);
    chk_res("fresh", 252, 1, 1);
    chk_idle("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
